// File: rtl/uart_rx_engine.sv
// UART receive engine: synchroniser, oversampling bit FSM and a first-word
// fall-through RX FIFO carrying parity/framing/break flags per word.
module uart_rx_engine #(
    parameter int MAX_DATA = 9,
    parameter int DEPTH    = 16,
    parameter int OVS      = 16,
    parameter int DIV_W    = 16
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic                     rx_en,
    input  logic [DIV_W-1:0]         baud_div,
    input  logic [3:0]               data_len,
    input  logic                     parity_en,
    input  logic                     parity_odd,
    input  logic                     stop_two,
    input  logic                     uart_rxd,
    input  logic                     rd_en,
    output logic [MAX_DATA-1:0]      rd_data,
    output logic [2:0]               rd_err,
    output logic                     fifo_empty,
    output logic                     fifo_full,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overrun,
    input  logic                     overrun_clr,
    output logic                     rx_busy
);

    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int SCW = $clog2(OVS);
    localparam int W   = MAX_DATA + 3;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_t;

    state_t state, next_state;

    logic sync1, sync2, rxd_prev;
    logic rxd_s, fall;

    logic [DIV_W-1:0] tick_cnt;
    logic             tick;
    logic [SCW-1:0]   samp_cnt;
    logic             bit_done;
    logic             start_go;

    logic [3:0]          len_clamped;
    logic [3:0]          len_q;
    logic                par_q, odd_q, stop2_q;
    logic [3:0]          bit_cnt;
    logic [MAX_DATA-1:0] data_q;
    logic                pe_q, fe_q, brk_q, zero_q;

    logic         push;
    logic         fe_now, brk_now;
    logic [W-1:0] push_word;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] count;
    logic          pop, push_ok, ovr_set;
    logic [W-1:0]  head;

    // The line idles high, so the synchroniser and edge history reset to 1.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            sync1    <= uart_rxd;
            sync2    <= sync1;
            rxd_prev <= sync2;
        end
    end

    assign rxd_s = sync2;
    assign fall  = rxd_prev & ~rxd_s;

    always_comb begin
        len_clamped = data_len;
        if (data_len < 4'd5) begin
            len_clamped = 4'd5;
        end else if (data_len > 4'(MAX_DATA)) begin
            len_clamped = 4'(MAX_DATA);
        end
    end

    assign tick = (tick_cnt == baud_div);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tick_cnt <= '0;
        end else if (start_go || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + DIV_W'(1);
        end
    end

    // START waits half a bit to land on the centre; later bits wait a full bit.
    assign bit_done = tick && ((state == START) ? (samp_cnt == SCW'(OVS/2 - 1))
                                                : (samp_cnt == SCW'(OVS - 1)));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            samp_cnt <= '0;
        end else if (start_go || bit_done) begin
            samp_cnt <= '0;
        end else if (tick) begin
            samp_cnt <= samp_cnt + SCW'(1);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start_go   = 1'b0;
        push       = 1'b0;
        if (!rx_en) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (fall) begin
                        next_state = START;
                        start_go   = 1'b1;
                    end
                end
                START: begin
                    if (bit_done) begin
                        next_state = rxd_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (bit_done && (bit_cnt == len_q - 4'd1)) begin
                        next_state = par_q ? PARITY : STOP1;
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        next_state = STOP1;
                    end
                end
                STOP1: begin
                    if (bit_done) begin
                        if (stop2_q) begin
                            next_state = STOP2;
                        end else begin
                            next_state = IDLE;
                            push       = 1'b1;
                        end
                    end
                end
                STOP2: begin
                    if (bit_done) begin
                        next_state = IDLE;
                        push       = 1'b1;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            len_q   <= 4'd5;
            par_q   <= 1'b0;
            odd_q   <= 1'b0;
            stop2_q <= 1'b0;
            bit_cnt <= '0;
            data_q  <= '0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            brk_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else if (start_go) begin
            len_q   <= len_clamped;
            par_q   <= parity_en;
            odd_q   <= parity_odd;
            stop2_q <= stop_two;
            bit_cnt <= '0;
            data_q  <= '0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            brk_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else if (bit_done) begin
            case (state)
                DATA: begin
                    data_q[bit_cnt] <= rxd_s;
                    bit_cnt         <= bit_cnt + 4'd1;
                    if (rxd_s) begin
                        zero_q <= 1'b0;
                    end
                end
                PARITY: begin
                    pe_q <= ((^data_q) ^ rxd_s) != odd_q;
                    if (rxd_s) begin
                        zero_q <= 1'b0;
                    end
                end
                STOP1: begin
                    fe_q  <= ~rxd_s;
                    brk_q <= zero_q & ~rxd_s;
                end
                default: ;
            endcase
        end
    end

    // Flags for the word being pushed include the stop bit sampled this cycle.
    always_comb begin
        fe_now  = fe_q | ~rxd_s;
        brk_now = brk_q;
        if (state == STOP1) begin
            fe_now  = ~rxd_s;
            brk_now = zero_q & ~rxd_s;
        end
        push_word = {brk_now, fe_now | brk_now, pe_q, data_q};
    end

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == LW'(DEPTH));
    assign pop        = rd_en & ~fifo_empty;
    assign push_ok    = push & (~fifo_full | pop);
    assign ovr_set    = push & fifo_full & ~pop;

    always_ff @(posedge PCLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            overrun <= 1'b0;
        end else if (ovr_set) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign head       = mem[rd_ptr];
    assign rd_data    = fifo_empty ? '0 : head[MAX_DATA-1:0];
    assign rd_err     = fifo_empty ? 3'b000 : head[W-1:MAX_DATA];
    assign fifo_level = count;
    assign rx_busy    = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_engine.sv
// Scoreboard bench for uart_rx_engine: serial frames are driven on uart_rxd and
// the expected FIFO words are queued and compared as they are read out.
module tb_uart_rx_engine;

    localparam int MAX_DATA = 9;
    localparam int DEPTH    = 4;
    localparam int OVS      = 16;
    localparam int DIV_W    = 16;

    logic                   PCLK = 1'b0;
    logic                   PRESETn = 1'b0;
    logic                   rx_en = 1'b0;
    logic [DIV_W-1:0]       baud_div = '0;
    logic [3:0]             data_len = 4'd8;
    logic                   parity_en = 1'b0;
    logic                   parity_odd = 1'b0;
    logic                   stop_two = 1'b0;
    logic                   uart_rxd = 1'b1;
    logic                   rd_en = 1'b0;
    logic                   overrun_clr = 1'b0;
    logic [MAX_DATA-1:0]    rd_data;
    logic [2:0]             rd_err;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   overrun;
    logic                   rx_busy;

    logic [11:0] sb [$];
    int checks = 0;
    int fails  = 0;

    uart_rx_engine #(
        .MAX_DATA(MAX_DATA),
        .DEPTH(DEPTH),
        .OVS(OVS),
        .DIV_W(DIV_W)
    ) dut (
        .PCLK(PCLK),
        .PRESETn(PRESETn),
        .rx_en(rx_en),
        .baud_div(baud_div),
        .data_len(data_len),
        .parity_en(parity_en),
        .parity_odd(parity_odd),
        .stop_two(stop_two),
        .uart_rxd(uart_rxd),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .rd_err(rd_err),
        .fifo_empty(fifo_empty),
        .fifo_full(fifo_full),
        .fifo_level(fifo_level),
        .overrun(overrun),
        .overrun_clr(overrun_clr),
        .rx_busy(rx_busy)
    );

    always #5 PCLK = ~PCLK;

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic set_cfg(input int div, input logic [3:0] len, input bit pen,
                           input bit podd, input bit two);
        baud_div   = DIV_W'(div);
        data_len   = len;
        parity_en  = pen;
        parity_odd = podd;
        stop_two   = two;
    endtask

    task automatic send_frame(input logic [8:0] data, input int nbits, input bit pen,
                              input bit pbit, input bit s1, input bit two, input bit s2,
                              input int bitcyc);
        uart_rxd = 1'b0;
        wait_cycles(bitcyc);
        for (int i = 0; i < nbits; i++) begin
            uart_rxd = data[i];
            wait_cycles(bitcyc);
        end
        if (pen) begin
            uart_rxd = pbit;
            wait_cycles(bitcyc);
        end
        uart_rxd = s1;
        wait_cycles(bitcyc);
        if (two) begin
            uart_rxd = s2;
            wait_cycles(bitcyc);
        end
        uart_rxd = 1'b1;
    endtask

    task automatic pop_word();
        rd_en = 1'b1;
        wait_cycles(1);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        wait_cycles(3);
        checks++;
        if (rd_data !== 9'h000) begin fails++; $display("[TB] FAIL reset_rd_data: got %0h expected 0", rd_data); end
        checks++;
        if (rd_err !== 3'b000) begin fails++; $display("[TB] FAIL reset_rd_err: got %b expected 000", rd_err); end
        checks++;
        if (fifo_empty !== 1'b1) begin fails++; $display("[TB] FAIL reset_empty: got %b expected 1", fifo_empty); end
        checks++;
        if (fifo_full !== 1'b0) begin fails++; $display("[TB] FAIL reset_full: got %b expected 0", fifo_full); end
        checks++;
        if (fifo_level !== 3'd0) begin fails++; $display("[TB] FAIL reset_level: got %0d expected 0", fifo_level); end
        checks++;
        if (overrun !== 1'b0) begin fails++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
        checks++;
        if (rx_busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", rx_busy); end
        PRESETn = 1'b1;
        rx_en   = 1'b1;
        wait_cycles(5);
    endtask

    task automatic test_8n1_basic();
        logic [11:0] exp;
        set_cfg(0, 4'd8, 1'b0, 1'b0, 1'b0);
        send_frame(9'h06D, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16);
        sb.push_back({3'b000, 9'h06D});
        checks++;
        if (rx_busy !== 1'b0) begin fails++; $display("[TB] FAIL 8n1_busy: got %b expected 0", rx_busy); end
        checks++;
        if (fifo_level !== 3'd1) begin fails++; $display("[TB] FAIL 8n1_level: got %0d expected 1", fifo_level); end
        wait_cycles(16);
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            checks++;
            if ({rd_err, rd_data} !== exp) begin fails++; $display("[TB] FAIL 8n1_head: got %h expected %h", {rd_err, rd_data}, exp); end
            pop_word();
        end
        checks++;
        if (fifo_empty !== 1'b1) begin fails++; $display("[TB] FAIL 8n1_empty: got %b expected 1", fifo_empty); end
    endtask

    task automatic test_parity();
        logic [11:0] exp;
        set_cfg(0, 4'd8, 1'b1, 1'b0, 1'b1);
        send_frame(9'h079, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16);
        sb.push_back({3'b000, 9'h079});
        wait_cycles(16);
        send_frame(9'h079, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16);
        sb.push_back({3'b001, 9'h079});
        wait_cycles(16);
        parity_odd = 1'b1;
        send_frame(9'h079, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16);
        sb.push_back({3'b001, 9'h079});
        wait_cycles(16);
        checks++;
        if (fifo_level !== 3'd3) begin fails++; $display("[TB] FAIL parity_level: got %0d expected 3", fifo_level); end
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            checks++;
            if ({rd_err, rd_data} !== exp) begin fails++; $display("[TB] FAIL parity_head: got %h expected %h", {rd_err, rd_data}, exp); end
            pop_word();
        end
        parity_odd = 1'b0;
    endtask

    task automatic test_framing_break();
        logic [11:0] exp;
        set_cfg(0, 4'd8, 1'b0, 1'b0, 1'b0);
        send_frame(9'h055, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16);
        sb.push_back({3'b010, 9'h055});
        wait_cycles(16);
        send_frame(9'h000, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16);
        sb.push_back({3'b110, 9'h000});
        wait_cycles(16);
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            checks++;
            if ({rd_err, rd_data} !== exp) begin fails++; $display("[TB] FAIL frame_head: got %h expected %h", {rd_err, rd_data}, exp); end
            pop_word();
        end
        checks++;
        if (fifo_empty !== 1'b1) begin fails++; $display("[TB] FAIL frame_empty: got %b expected 1", fifo_empty); end
    endtask

    task automatic test_glitch();
        set_cfg(0, 4'd8, 1'b0, 1'b0, 1'b0);
        uart_rxd = 1'b0;
        wait_cycles(4);
        uart_rxd = 1'b1;
        wait_cycles(2);
        checks++;
        if (rx_busy !== 1'b1) begin fails++; $display("[TB] FAIL glitch_start: got %b expected 1", rx_busy); end
        wait_cycles(30);
        checks++;
        if (rx_busy !== 1'b0) begin fails++; $display("[TB] FAIL glitch_idle: got %b expected 0", rx_busy); end
        checks++;
        if (fifo_empty !== 1'b1) begin fails++; $display("[TB] FAIL glitch_empty: got %b expected 1", fifo_empty); end
    endtask

    task automatic test_overrun();
        logic [11:0] exp;
        set_cfg(0, 4'd8, 1'b0, 1'b0, 1'b0);
        for (int v = 1; v <= 5; v++) begin
            send_frame(9'(v), 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16);
            if (v <= DEPTH) sb.push_back({3'b000, 9'(v)});
            wait_cycles(16);
        end
        checks++;
        if (fifo_full !== 1'b1) begin fails++; $display("[TB] FAIL ovr_full: got %b expected 1", fifo_full); end
        checks++;
        if (overrun !== 1'b1) begin fails++; $display("[TB] FAIL ovr_set: got %b expected 1", overrun); end
        checks++;
        if (fifo_level !== 3'd4) begin fails++; $display("[TB] FAIL ovr_level: got %0d expected 4", fifo_level); end
        overrun_clr = 1'b1;
        wait_cycles(1);
        overrun_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin fails++; $display("[TB] FAIL ovr_clr: got %b expected 0", overrun); end
        // Push lands 155 cycles after the start bit: 3 to detect, 8 to centre, 9 bits of 16.
        exp = sb.pop_front();
        checks++;
        if ({rd_err, rd_data} !== exp) begin fails++; $display("[TB] FAIL ovr_head: got %h expected %h", {rd_err, rd_data}, exp); end
        sb.push_back({3'b000, 9'h006});
        fork
            send_frame(9'h006, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16);
            begin
                wait_cycles(154);
                rd_en = 1'b1;
                wait_cycles(1);
                rd_en = 1'b0;
            end
        join
        wait_cycles(16);
        checks++;
        if (fifo_level !== 3'd4) begin fails++; $display("[TB] FAIL simul_level: got %0d expected 4", fifo_level); end
        checks++;
        if (overrun !== 1'b0) begin fails++; $display("[TB] FAIL simul_overrun: got %b expected 0", overrun); end
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            checks++;
            if ({rd_err, rd_data} !== exp) begin fails++; $display("[TB] FAIL ovr_drain: got %h expected %h", {rd_err, rd_data}, exp); end
            pop_word();
        end
        checks++;
        if (fifo_empty !== 1'b1) begin fails++; $display("[TB] FAIL ovr_empty: got %b expected 1", fifo_empty); end
    endtask

    task automatic test_rx_disable();
        logic [11:0] exp;
        set_cfg(0, 4'd8, 1'b0, 1'b0, 1'b0);
        send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16);
        sb.push_back({3'b000, 9'h03C});
        wait_cycles(16);
        uart_rxd = 1'b0;
        wait_cycles(40);
        checks++;
        if (rx_busy !== 1'b1) begin fails++; $display("[TB] FAIL dis_busy: got %b expected 1", rx_busy); end
        rx_en = 1'b0;
        wait_cycles(1);
        checks++;
        if (rx_busy !== 1'b0) begin fails++; $display("[TB] FAIL dis_idle: got %b expected 0", rx_busy); end
        uart_rxd = 1'b1;
        wait_cycles(20);
        rx_en = 1'b1;
        wait_cycles(20);
        checks++;
        if (fifo_level !== 3'd1) begin fails++; $display("[TB] FAIL dis_level: got %0d expected 1", fifo_level); end
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            checks++;
            if ({rd_err, rd_data} !== exp) begin fails++; $display("[TB] FAIL dis_head: got %h expected %h", {rd_err, rd_data}, exp); end
            pop_word();
        end
    endtask

    task automatic test_len5_reset();
        logic [11:0] exp;
        set_cfg(3, 4'd5, 1'b1, 1'b1, 1'b0);
        send_frame(9'h015, 5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 64);
        sb.push_back({3'b000, 9'h015});
        wait_cycles(64);
        checks++;
        if (fifo_level !== 3'd1) begin fails++; $display("[TB] FAIL len5_level: got %0d expected 1", fifo_level); end
        exp = sb.pop_front();
        checks++;
        if ({rd_err, rd_data} !== exp) begin fails++; $display("[TB] FAIL len5_head: got %h expected %h", {rd_err, rd_data}, exp); end
        uart_rxd = 1'b0;
        wait_cycles(200);
        checks++;
        if (rx_busy !== 1'b1) begin fails++; $display("[TB] FAIL mid_busy: got %b expected 1", rx_busy); end
        PRESETn = 1'b0;
        #1;
        checks++;
        if (rx_busy !== 1'b0) begin fails++; $display("[TB] FAIL rst_busy: got %b expected 0", rx_busy); end
        checks++;
        if (fifo_empty !== 1'b1) begin fails++; $display("[TB] FAIL rst_empty: got %b expected 1", fifo_empty); end
        checks++;
        if (fifo_level !== 3'd0) begin fails++; $display("[TB] FAIL rst_level: got %0d expected 0", fifo_level); end
        checks++;
        if ({rd_err, rd_data} !== 12'h000) begin fails++; $display("[TB] FAIL rst_head: got %h expected 000", {rd_err, rd_data}); end
        uart_rxd = 1'b1;
        wait_cycles(5);
        PRESETn = 1'b1;
        wait_cycles(10);
        data_len = 4'd3;
        send_frame(9'h00A, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 64);
        sb.push_back({3'b000, 9'h00A});
        wait_cycles(64);
        checks++;
        if (fifo_level !== 3'd1) begin fails++; $display("[TB] FAIL clamp_level: got %0d expected 1", fifo_level); end
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            checks++;
            if ({rd_err, rd_data} !== exp) begin fails++; $display("[TB] FAIL clamp_head: got %h expected %h", {rd_err, rd_data}, exp); end
            pop_word();
        end
    endtask

    initial begin
        test_reset();
        test_8n1_basic();
        test_parity();
        test_framing_break();
        test_glitch();
        test_overrun();
        test_rx_disable();
        test_len5_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
